// File: rtl/bitplane_loader_if.sv
// Bitplane loader bus: element stream in, transposed batch out.
// master = producer/sorter side, slave = loader side.
interface bitplane_loader_if #(
  parameter int unsigned ELEMENT_NUM = 8,
  parameter int unsigned DATA_WIDTH  = 8
);
  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_last;
  logic                              in_ready;
  logic [DATA_WIDTH*ELEMENT_NUM-1:0] planes;
  logic [ELEMENT_NUM-1:0]            elem_mask;
  logic                              planes_valid;
  logic                              planes_ack;

  modport master (
    output in_valid, in_data, in_last, planes_ack,
    input  in_ready, planes, elem_mask, planes_valid
  );

  modport slave (
    input  in_valid, in_data, in_last, planes_ack,
    output in_ready, planes, elem_mask, planes_valid
  );
endinterface

// File: rtl/bitplane_loader.sv
// Bitplane loader: accepts up to ELEMENT_NUM elements, stores them transposed
// as DATA_WIDTH bit-planes (plane k, column i = bit k of element i), and holds
// the batch until the sorter acknowledges it.
// Optional macro LOADER_INVERT_EN: store the complement of each element so the
// downstream narrowing selects the minimum instead of the maximum.
module bitplane_loader #(
  parameter int unsigned ELEMENT_NUM = 8,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst,
  bitplane_loader_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(ELEMENT_NUM + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(ELEMENT_NUM - 1);

  typedef enum logic {LOAD, FULL} state_t;

  state_t                            state;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [DATA_WIDTH*ELEMENT_NUM-1:0] planes_r;
  logic [ELEMENT_NUM-1:0]            mask_r;
  logic                              ready_r;
  logic                              valid_r;
  logic [DATA_WIDTH-1:0]             store_data;

`ifdef LOADER_INVERT_EN
  assign store_data = ~bus.in_data;
`else
  assign store_data = bus.in_data;
`endif

  // Load/hold FSM; in_ready and planes_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      planes_r <= '0;
      mask_r   <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            // Column decode: scatter each data bit into its plane at slot wr_ptr.
            for (int unsigned i = 0; i < ELEMENT_NUM; i++) begin
              if (wr_ptr == PTR_W'(i)) begin
                mask_r[i] <= 1'b1;
                for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
                  planes_r[k*ELEMENT_NUM + i] <= store_data[k];
                end
              end
            end
            wr_ptr <= wr_ptr + 1'b1;
            if (bus.in_last || (wr_ptr == LAST_SLOT)) begin
              state   <= FULL;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.planes_ack) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            planes_r <= '0;
            mask_r   <= '0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
          end
        end
        default: begin
          state   <= LOAD;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = ready_r;
  assign bus.planes_valid = valid_r;
  assign bus.planes       = planes_r;
  assign bus.elem_mask    = mask_r;
endmodule

// File: doc/bitplane_loader.md
BITPLANE_LOADER -- requirements
Module: bitplane_loader

Interface
REQ-001 Parameter ELEMENT_NUM, default 8, number of element slots (columns) per sort batch.
REQ-002 Parameter DATA_WIDTH, default 8, bits per element; one bit-plane per bit.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers in_data this cycle.
REQ-006 in_data  input  DATA_WIDTH  element value, unsigned.
REQ-007 in_last  input  1  marks the final element of a batch when in_valid is high.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 planes  output  DATA_WIDTH*ELEMENT_NUM  transposed batch; plane k = planes[k*ELEMENT_NUM +: ELEMENT_NUM]; bit i of plane k = bit k of element i.
REQ-010 elem_mask  output  ELEMENT_NUM  bit i high iff slot i holds a loaded element; the sorter's initial event vector.
REQ-011 planes_valid  output  1  batch complete, planes and elem_mask stable.
REQ-012 planes_ack  input  1  sorter has consumed the batch; releases the planes.

Function
REQ-013 The loader SHALL implement states LOAD and FULL; reset state LOAD.
REQ-014 In LOAD, in_ready SHALL be 1; in FULL, in_ready SHALL be 0.
REQ-015 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; no transfer otherwise.
REQ-016 On a transfer, the loader SHALL write in_data bit k into plane k at column wr_ptr for all k, set elem_mask[wr_ptr], and increment wr_ptr.
REQ-017 wr_ptr SHALL be a counter of width clog2(ELEMENT_NUM+1), starting at 0 for each batch.
REQ-018 The transition LOAD->FULL SHALL occur on the cycle after a transfer that has in_last=1 or that fills slot ELEMENT_NUM-1; in_last on the final slot is the same single event.
REQ-019 Columns not written in a partial batch SHALL hold 0 in every plane and 0 in elem_mask.
REQ-020 planes_valid SHALL equal 1 exactly while in FULL; latency from the last transfer edge to planes_valid=1 is one cycle.
REQ-021 In FULL, planes and elem_mask SHALL not change until release.
REQ-022 In FULL, planes_ack=1 SHALL on the next edge clear all planes, elem_mask and wr_ptr and return to LOAD; in_ready=1 in the following cycle.
REQ-023 planes_ack while in LOAD SHALL be ignored.
REQ-024 in_last with in_valid=0 or in_ready=0 SHALL be ignored.
REQ-025 No transfer SHALL occur in the cycle planes_ack is sampled in FULL (in_ready is 0); no element is lost or overwritten.
REQ-026 planes_valid with elem_mask all-zero SHALL never occur; an empty batch cannot be produced.

Reset
REQ-027 With rst=1 at an edge, the loader SHALL enter LOAD, clear planes, elem_mask and wr_ptr to 0; outputs after that edge: in_ready=1, planes_valid=0.
REQ-028 Reset asserted mid-batch or in FULL SHALL discard the partial or complete batch with no output pulse; rst has priority over transfers and planes_ack.

Configuration
REQ-029 Macro LOADER_INVERT_EN SHALL select the stored polarity.
REQ-030 With LOADER_INVERT_EN defined, each transfer SHALL write the bitwise complement of in_data; the downstream AND/OR narrowing then selects the minimum instead of the maximum. Unwritten columns stay 0 and stay masked off by elem_mask.
REQ-031 Without LOADER_INVERT_EN, in_data SHALL be written unmodified.

Verification
REQ-032 Full batch, ELEMENT_NUM=8, DATA_WIDTH=8: values 3,7,1,0,255,128,9,4 are sent back-to-back with in_last on the 8th. Required: planes_valid=1 one cycle after the 8th edge; plane 7 = 8'b0011_0000; elem_mask=8'hFF.
REQ-033 Partial batch: values 5,2,6 are sent with in_last on the 3rd. Required: elem_mask=8'h07; plane 0=8'b0000_0001; plane 2=8'b0000_0101; columns 3..7 are 0.
REQ-034 Backpressure and release: in FULL, in_valid is held at 1 with value 9. Required: in_ready=0 and planes stay unchanged. Then planes_ack is pulsed. Required: next cycle in_ready=1, elem_mask=0, and value 9 is then loaded into slot 0.
REQ-035 Reset mid-batch: rst is asserted after 4 transfers. Required: elem_mask=0, planes_valid=0. A fresh 2-element batch then loads into slots 0-1.
REQ-036 With LOADER_INVERT_EN defined, a single element 8'hF0 is sent with in_last. Required: planes 0-3 bit 0 = 1, planes 4-7 bit 0 = 0, elem_mask=8'h01.
REQ-037 Stray inputs in LOAD: planes_ack is pulsed, and separately in_last is driven with in_valid=0. Required: no state change and planes_valid stays 0.
